// File: rtl/timer_pkg.sv
// Shared definitions for the pattern-triggered timer: state encoding and
// parameter defaults used by the shift enabler, pattern FSM and delay counter.
package timer_pkg;

  localparam int unsigned DELAY_W_DEF     = 4;
  localparam int unsigned TICK_PERIOD_DEF = 1000;
  localparam int unsigned PRESC_W_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running cycle prescaler: emits a one-cycle tick while the counter sits
// at TICK_PERIOD-1, then wraps to zero.
module tick_prescaler #(
  parameter int unsigned TICK_PERIOD = timer_pkg::TICK_PERIOD_DEF,
  parameter int unsigned PRESC_W     = timer_pkg::PRESC_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_PERIOD - 1);
  localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(TICK_PERIOD - 2);

  logic [PRESC_W-1:0] presc_q;

  // tick is registered one cycle early so it lines up with presc_q == PRESC_LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      presc_q <= '0;
      tick    <= 1'b0;
    end else if (enable) begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
      tick    <= (presc_q == PRESC_PRE);
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/delay_shift_counter.sv
// Delay loader and countdown for the pattern-triggered timer: shifts the delay
// in MSB first, counts (delay+1)*TICK_PERIOD cycles, then holds done until ack.
module delay_shift_counter
  import timer_pkg::*;
#(
  parameter int unsigned DELAY_W     = DELAY_W_DEF,
  parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEF,
  parameter int unsigned PRESC_W     = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_ena,
  input  logic               data,
  input  logic               ack,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  timer_state_t       state_q, state_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [DELAY_W-1:0] count_d;
  logic               counting_d, done_d;
  logic               presc_clear, presc_en, tick;

  // prescaler only runs in COUNT, so it always starts a period from zero
  assign presc_clear = (state_q != COUNT);
  assign presc_en    = (state_q == COUNT);

  tick_prescaler #(
    .TICK_PERIOD (TICK_PERIOD),
    .PRESC_W     (PRESC_W)
  ) u_tick_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (tick)
  );

  // next-state, shift register, down-counter and output decode
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    count_d    = count;
    counting_d = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (shift_ena) begin
          delay_d = DELAY_W'(data);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (shift_ena) begin
          delay_d = {delay_q[DELAY_W-2:0], data};
        end else begin
          count_d = delay_q;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (tick) begin
          if (count == '0) state_d = DONE;
          else             count_d = count - DELAY_W'(1);
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    counting_d = (state_d == COUNT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      delay_q  <= '0;
      count    <= '0;
      counting <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      count    <= count_d;
      counting <= counting_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_delay_shift_counter.sv
// Randomized and directed bench for delay_shift_counter with TICK_PERIOD=4,
// compared against a cycle-count model derived from the delay value.
module tb_delay_shift_counter;

  localparam int DW = 4;
  localparam int TP = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          shift_ena = 1'b0;
  logic          data = 1'b0;
  logic          ack = 1'b0;
  logic [DW-1:0] count;
  logic          counting;
  logic          done;

  int n_pass = 0;
  int n_total = 0;
  int trace[$];

  always #5 clk = ~clk;

  delay_shift_counter #(
    .DELAY_W     (DW),
    .TICK_PERIOD (TP),
    .PRESC_W     (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .shift_ena (shift_ena),
    .data      (data),
    .ack       (ack),
    .count     (count),
    .counting  (counting),
    .done      (done)
  );

  // shift len bits of val, MSB first; leaves shift_ena low for the next edge
  task automatic load_bits(input int val, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      shift_ena = 1'b1;
      data      = 1'((val >> i) & 1);
      @(negedge clk);
    end
    shift_ena = 1'b0;
    data      = 1'b0;
  endtask

  // record count on every cycle counting is high; optionally drive junk inputs
  task automatic capture(input bit noise);
    trace.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (counting === 1'b1) begin
        trace.push_back(int'(count));
        if (noise) begin
          shift_ena = 1'($urandom_range(0, 1));
          data      = 1'($urandom_range(0, 1));
          ack       = 1'($urandom_range(0, 1));
        end
      end else if (trace.size() != 0) begin
        break;
      end
    end
    shift_ena = 1'b0;
    data      = 1'b0;
    ack       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (counting !== 1'b0 || done !== 1'b0 || count !== '0)
      $display("FAIL reset_outputs: got counting=%b done=%b count=%0d want 0/0/0", counting, done, count);
    else n_pass++;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (counting !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle_hold: got counting=%b done=%b want 0/0", counting, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    int pv[4] = '{10, 0, 51, 3};
    int pl[4] = '{4, 4, 6, 2};
    int d, exp;
    for (int t = 0; t < 4; t++) begin
      d = pv[t] % (1 << DW);
      load_bits(pv[t], pl[t]);
      capture(1'b0);
      n_total++;
      if (trace.size() != (d + 1) * TP)
        $display("FAIL dir%0d_len: got %0d cycles want %0d", t, trace.size(), (d + 1) * TP);
      else n_pass++;
      for (int i = 0; i < trace.size(); i++) begin
        exp = d - i / TP;
        n_total++;
        if (trace[i] != exp) $display("FAIL dir%0d_count[%0d]: got %0d want %0d", t, i, trace[i], exp);
        else n_pass++;
      end
      n_total++;
      if (done !== 1'b1 || counting !== 1'b0 || count !== '0)
        $display("FAIL dir%0d_done: got done=%b counting=%b count=%0d want 1/0/0", t, done, counting, count);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (done !== 1'b1) $display("FAIL dir%0d_done_hold: got %b want 1", t, done);
      else n_pass++;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      n_total++;
      if (done !== 1'b0 || counting !== 1'b0)
        $display("FAIL dir%0d_ack: got done=%b counting=%b want 0/0", t, done, counting);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int len, val, d, exp;
    bit noise;
    for (int t = 0; t < 10; t++) begin
      len   = $urandom_range(1, 7);
      val   = $urandom_range(0, (1 << len) - 1);
      noise = 1'($urandom_range(0, 1));
      d     = val % (1 << DW);
      load_bits(val, len);
      capture(noise);
      n_total++;
      if (trace.size() != (d + 1) * TP)
        $display("FAIL rnd%0d_len: val=%0d len=%0d got %0d cycles want %0d", t, val, len, trace.size(), (d + 1) * TP);
      else n_pass++;
      for (int i = 0; i < trace.size(); i++) begin
        exp = d - i / TP;
        n_total++;
        if (trace[i] != exp) $display("FAIL rnd%0d_count[%0d]: got %0d want %0d", t, i, trace[i], exp);
        else n_pass++;
      end
      n_total++;
      if (done !== 1'b1 || count !== '0)
        $display("FAIL rnd%0d_done: got done=%b count=%0d want 1/0", t, done, count);
      else n_pass++;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      n_total++;
      if (done !== 1'b0) $display("FAIL rnd%0d_ack: got done=%b want 0", t, done);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    load_bits(10, 4);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (counting === 1'b1 && count === DW'(5)) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL areset_reach5: got count=%0d counting=%b want 5/1", count, counting);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (counting !== 1'b0 || done !== 1'b0 || count !== '0)
      $display("FAIL areset_immediate: got counting=%b done=%b count=%0d want 0/0/0", counting, done, count);
    else n_pass++;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (counting !== 1'b0 || done !== 1'b0 || count !== '0)
      $display("FAIL areset_stays_idle: got counting=%b done=%b count=%0d want 0/0/0", counting, done, count);
    else n_pass++;
  endtask

  task automatic test_ack_with_shift();
    // ack taken together with shift_ena, which then drops: no load may start
    load_bits(1, 1);
    capture(1'b0);
    n_total++;
    if (done !== 1'b1) $display("FAIL ackshift_a_done: got %b want 1", done);
    else n_pass++;
    ack = 1'b1; shift_ena = 1'b1; data = 1'b1;
    @(negedge clk);
    ack = 1'b0; shift_ena = 1'b0; data = 1'b0;
    n_total++;
    if (done !== 1'b0) $display("FAIL ackshift_a_ack: got done=%b want 0", done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (counting !== 1'b0) $display("FAIL ackshift_a_noload: got counting=%b want 0", counting);
    else n_pass++;
    // shift_ena held past the ack cycle: only bits seen in IDLE onward count
    load_bits(2, 2);
    capture(1'b0);
    ack = 1'b1; shift_ena = 1'b1; data = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if (done !== 1'b0) $display("FAIL ackshift_b_ack: got done=%b want 0", done);
    else n_pass++;
    load_bits(1, 2);
    capture(1'b0);
    n_total++;
    if (trace.size() != 2 * TP || trace[0] != 1)
      $display("FAIL ackshift_b_load: got %0d cycles first count %0d want %0d cycles first count 1",
               trace.size(), (trace.size() != 0) ? trace[0] : -1, 2 * TP);
    else n_pass++;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_total++;
    if (done !== 1'b0) $display("FAIL ackshift_b_final_ack: got done=%b want 0", done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_async_reset();
    test_ack_with_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
